// File: rtl/axil_master_pkg.sv
// Shared types and constants for the AXI4-Lite MMIO initiator.
package axil_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_WR_ADDR_DATA = 3'd1,
    ST_WR_RESP      = 3'd2,
    ST_RD_ADDR      = 3'd3,
    ST_RD_DATA      = 3'd4,
    ST_DONE         = 3'd5
  } axil_state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Anything other than a plain OKAY is reported to the core as an error.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/axil_master_if.sv
// AXI4-Lite bus between the core MMIO initiator and the interconnect.
interface axil_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axil_master.sv
// Single-outstanding AXI4-Lite initiator for MMIO loads/stores from MEM1.
//
//  state           | meaning
//  ----------------+--------------------------------------------------
//  ST_IDLE         | waiting for AXIL_EN; request fields latched on accept
//  ST_WR_ADDR_DATA | AW and W offered, each retired independently
//  ST_WR_RESP      | BREADY high, waiting for the write response
//  ST_RD_ADDR      | ARVALID high, waiting for ARREADY
//  ST_RD_DATA      | RREADY high, waiting for read data
//  ST_DONE         | done pulse cycle; AXIL_EN ignored
//
// Every output is a flop, so AXI inputs never reach an output combinationally.
// If AXIL_EN falls while busy, the bus transaction still finishes but the
// core sees no done pulse and no RDATA/ERR update.
module axil_master
  import axil_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    AXIL_EN,
  input  logic                    AXIL_WE,
  input  logic [ADDR_WIDTH-1:0]   AXIL_ADDR,
  input  logic [DATA_WIDTH-1:0]   AXIL_WDATA,
  input  logic [DATA_WIDTH/8-1:0] AXIL_WSTRB,
  output logic                    AXIL_DONE_READ,
  output logic                    AXIL_DONE_WRITE,
  output logic [DATA_WIDTH-1:0]   AXIL_RDATA,
  output logic                    AXIL_ERR,
  axil_master_if.master           m_axi
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  axil_state_t r_state, w_state_nxt;

  logic [ADDR_WIDTH-1:0] r_addr,  w_addr_nxt;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata_nxt;
  logic [STRB_WIDTH-1:0] r_wstrb, w_wstrb_nxt;
  logic                  r_awvalid, w_awvalid_nxt;
  logic                  r_wvalid,  w_wvalid_nxt;
  logic                  r_bready,  w_bready_nxt;
  logic                  r_arvalid, w_arvalid_nxt;
  logic                  r_rready,  w_rready_nxt;
  logic                  r_aw_sent, w_aw_sent_nxt;
  logic                  r_w_sent,  w_w_sent_nxt;
  logic                  r_cancel,  w_cancel_nxt;
  logic                  r_done_rd, w_done_rd_nxt;
  logic                  r_done_wr, w_done_wr_nxt;
  logic                  r_err,     w_err_nxt;
  logic [DATA_WIDTH-1:0] r_rdata,   w_rdata_nxt;

  logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic w_aw_done, w_w_done, w_cancel;

  assign w_aw_hs   = r_awvalid & m_axi.awready;
  assign w_w_hs    = r_wvalid  & m_axi.wready;
  assign w_b_hs    = r_bready  & m_axi.bvalid;
  assign w_ar_hs   = r_arvalid & m_axi.arready;
  assign w_r_hs    = r_rready  & m_axi.rvalid;
  assign w_aw_done = r_aw_sent | w_aw_hs;
  assign w_w_done  = r_w_sent  | w_w_hs;
  // Includes the current cycle so a flush on the completing edge still counts.
  assign w_cancel  = r_cancel | ~AXIL_EN;

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode from handshakes and the request.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:         if (AXIL_EN) w_state_nxt = AXIL_WE ? ST_WR_ADDR_DATA : ST_RD_ADDR;
      ST_WR_ADDR_DATA: if (w_aw_done && w_w_done) w_state_nxt = ST_WR_RESP;
      ST_WR_RESP:      if (w_b_hs) w_state_nxt = w_cancel ? ST_IDLE : ST_DONE;
      ST_RD_ADDR:      if (w_ar_hs) w_state_nxt = ST_RD_DATA;
      ST_RD_DATA:      if (w_r_hs) w_state_nxt = w_cancel ? ST_IDLE : ST_DONE;
      ST_DONE:         w_state_nxt = ST_IDLE;
      default:         w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values of every registered output and capture register.
  always_comb begin
    w_addr_nxt    = r_addr;
    w_wdata_nxt   = r_wdata;
    w_wstrb_nxt   = r_wstrb;
    w_awvalid_nxt = r_awvalid;
    w_wvalid_nxt  = r_wvalid;
    w_bready_nxt  = r_bready;
    w_arvalid_nxt = r_arvalid;
    w_rready_nxt  = r_rready;
    w_aw_sent_nxt = r_aw_sent;
    w_w_sent_nxt  = r_w_sent;
    w_cancel_nxt  = r_cancel;
    w_err_nxt     = r_err;
    w_rdata_nxt   = r_rdata;
    w_done_rd_nxt = 1'b0;
    w_done_wr_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (AXIL_EN) begin
          w_addr_nxt    = AXIL_ADDR;
          w_wdata_nxt   = AXIL_WDATA;
          w_wstrb_nxt   = AXIL_WSTRB;
          w_aw_sent_nxt = 1'b0;
          w_w_sent_nxt  = 1'b0;
          w_cancel_nxt  = 1'b0;
          if (AXIL_WE) begin
            w_awvalid_nxt = 1'b1;
            w_wvalid_nxt  = 1'b1;
          end else begin
            w_arvalid_nxt = 1'b1;
          end
        end
      end
      ST_WR_ADDR_DATA: begin
        w_cancel_nxt = w_cancel;
        if (w_aw_hs) begin
          w_awvalid_nxt = 1'b0;
          w_aw_sent_nxt = 1'b1;
        end
        if (w_w_hs) begin
          w_wvalid_nxt = 1'b0;
          w_w_sent_nxt = 1'b1;
        end
        if (w_aw_done && w_w_done) w_bready_nxt = 1'b1;
      end
      ST_WR_RESP: begin
        w_cancel_nxt = w_cancel;
        if (w_b_hs) begin
          w_bready_nxt = 1'b0;
          if (!w_cancel) begin
            w_err_nxt     = resp_is_err(m_axi.bresp);
            w_done_wr_nxt = 1'b1;
          end
        end
      end
      ST_RD_ADDR: begin
        w_cancel_nxt = w_cancel;
        if (w_ar_hs) begin
          w_arvalid_nxt = 1'b0;
          w_rready_nxt  = 1'b1;
        end
      end
      ST_RD_DATA: begin
        w_cancel_nxt = w_cancel;
        if (w_r_hs) begin
          w_rready_nxt = 1'b0;
          if (!w_cancel) begin
            w_rdata_nxt   = m_axi.rdata;
            w_err_nxt     = resp_is_err(m_axi.rresp);
            w_done_rd_nxt = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Output and capture registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_aw_sent <= 1'b0;
      r_w_sent  <= 1'b0;
      r_cancel  <= 1'b0;
      r_done_rd <= 1'b0;
      r_done_wr <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_addr    <= w_addr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_wstrb   <= w_wstrb_nxt;
      r_awvalid <= w_awvalid_nxt;
      r_wvalid  <= w_wvalid_nxt;
      r_bready  <= w_bready_nxt;
      r_arvalid <= w_arvalid_nxt;
      r_rready  <= w_rready_nxt;
      r_aw_sent <= w_aw_sent_nxt;
      r_w_sent  <= w_w_sent_nxt;
      r_cancel  <= w_cancel_nxt;
      r_done_rd <= w_done_rd_nxt;
      r_done_wr <= w_done_wr_nxt;
      r_err     <= w_err_nxt;
      r_rdata   <= w_rdata_nxt;
    end
  end

  assign m_axi.awaddr  = r_addr;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = r_awvalid;
  assign m_axi.wdata   = r_wdata;
  assign m_axi.wstrb   = r_wstrb;
  assign m_axi.wvalid  = r_wvalid;
  assign m_axi.bready  = r_bready;
  assign m_axi.araddr  = r_addr;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = r_arvalid;
  assign m_axi.rready  = r_rready;

  assign AXIL_DONE_READ  = r_done_rd;
  assign AXIL_DONE_WRITE = r_done_wr;
  assign AXIL_RDATA      = r_rdata;
  assign AXIL_ERR        = r_err;

endmodule

// File: tb/tb_axil_master.sv
// Bench for axil_master: a cycle-stepped slave with per-channel delays and a
// transaction-level model of what the core should observe.
module tb_axil_master;
  import axil_master_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en, we;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic        done_rd, done_wr, err;
  logic [31:0] rdata_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the core-visible results.
  logic [31:0] m_rdata = '0;
  logic        m_err   = 1'b0;

  always #5 clk = ~clk;

  axil_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axil_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .CLK(clk), .RST_N(rst_n),
    .AXIL_EN(en), .AXIL_WE(we), .AXIL_ADDR(addr), .AXIL_WDATA(wdata), .AXIL_WSTRB(wstrb),
    .AXIL_DONE_READ(done_rd), .AXIL_DONE_WRITE(done_wr), .AXIL_RDATA(rdata_o), .AXIL_ERR(err),
    .m_axi(bus)
  );

  task automatic slave_idle;
    bus.awready = 1'b0; bus.wready = 1'b0;
    bus.bvalid  = 1'b0; bus.bresp  = 2'b00;
    bus.arready = 1'b0; bus.rvalid = 1'b0;
    bus.rdata   = '0;   bus.rresp  = 2'b00;
  endtask

  // Runs one transaction from the negedge of cycle 0. Slave inputs are updated
  // at each negedge from the DUT's registered outputs of that cycle.
  task automatic do_txn(input bit t_we, input logic [31:0] t_addr, input logic [31:0] t_wdata,
                        input logic [3:0] t_strb, input logic [1:0] t_resp, input logic [31:0] t_rdata,
                        input int awd, input int wd, input int bd, input int ard, input int rd,
                        input int cancel_cyc, input bit wiggle, input string name);
    int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, r_cnt = 0, b_cnt = 0;
    bit ar_done = 0, aw_done = 0, w_done = 0, r_pend = 0, b_pend = 0, b_armed = 0;
    bit ar_fire = 0, aw_fire = 0, w_fire = 0, r_fire = 0, b_fire = 0, bus_done = 0;
    int aw_cyc = -1, w_cyc = -1, done_cyc = -1, end_cyc = 0, bready_cyc = -1;
    int n_drd = 0, n_dwr = 0, viol = 0, exp_lat, last_hs;
    logic [31:0] cap_addr = '0, cap_wdata = '0;
    logic [3:0]  cap_strb = '0;
    bit cancelled;
    cancelled = (cancel_cyc > 0);
    en = 1'b1; we = t_we; addr = t_addr; wdata = t_wdata; wstrb = t_strb;
    for (int k = 1; k <= 80; k++) begin
      if (bus_done && k > end_cyc + 2) break;
      @(negedge clk);
      if (k == 2 && wiggle) begin
        addr = ~t_addr; wdata = ~t_wdata; wstrb = ~t_strb; we = ~t_we;
      end
      if (k == cancel_cyc) en = 1'b0;
      if (done_rd) begin n_drd++; if (done_cyc < 0) done_cyc = k; en = 1'b0; end
      if (done_wr) begin n_dwr++; if (done_cyc < 0) done_cyc = k; en = 1'b0; end
      // retire handshakes that completed on the last edge
      if (ar_fire) begin bus.arready = 1'b0; ar_fire = 0; r_pend = 1; end
      if (aw_fire) begin bus.awready = 1'b0; aw_fire = 0; end
      if (w_fire)  begin bus.wready  = 1'b0; w_fire  = 0; end
      if (r_fire)  begin bus.rvalid  = 1'b0; r_fire  = 0; bus_done = 1; end_cyc = k - 1; end
      if (b_fire)  begin bus.bvalid  = 1'b0; b_fire  = 0; bus_done = 1; end_cyc = k - 1; end
      if (aw_done && w_done && !b_armed) begin b_armed = 1; b_pend = 1; end
      if (bus.bready && bready_cyc < 0) bready_cyc = k;
      // protocol: no VALID after its handshake, no drop before it, no wrong direction
      if (ar_done && bus.arvalid) viol++;
      if (aw_done && bus.awvalid) viol++;
      if (w_done && bus.wvalid) viol++;
      if (ar_cnt > 0 && !ar_done && !bus.arvalid) viol++;
      if (aw_cnt > 0 && !aw_done && !bus.awvalid) viol++;
      if (w_cnt > 0 && !w_done && !bus.wvalid) viol++;
      if (t_we && (bus.arvalid || bus.rready)) viol++;
      if (!t_we && (bus.awvalid || bus.wvalid || bus.bready)) viol++;
      // read channels
      if (!ar_done && bus.arvalid) begin
        if (bus.araddr !== t_addr) viol++;
        bus.arready = (ar_cnt >= ard);
        ar_cnt++;
        if (bus.arready) begin ar_fire = 1; ar_done = 1; cap_addr = bus.araddr; end
      end
      if (r_pend && !bus.rvalid) begin
        if (r_cnt >= rd) begin bus.rvalid = 1'b1; bus.rdata = t_rdata; bus.rresp = t_resp; end
        else r_cnt++;
      end
      if (bus.rvalid && bus.rready) begin r_fire = 1; r_pend = 0; end
      // write channels
      if (!aw_done && bus.awvalid) begin
        if (bus.awaddr !== t_addr) viol++;
        bus.awready = (aw_cnt >= awd);
        aw_cnt++;
        if (bus.awready) begin aw_fire = 1; aw_done = 1; aw_cyc = k; cap_addr = bus.awaddr; end
      end
      if (!w_done && bus.wvalid) begin
        if (bus.wdata !== t_wdata || bus.wstrb !== t_strb) viol++;
        bus.wready = (w_cnt >= wd);
        w_cnt++;
        if (bus.wready) begin
          w_fire = 1; w_done = 1; w_cyc = k; cap_wdata = bus.wdata; cap_strb = bus.wstrb;
        end
      end
      if (b_pend && !bus.bvalid) begin
        if (b_cnt >= bd) begin bus.bvalid = 1'b1; bus.bresp = t_resp; end
        else b_cnt++;
      end
      if (bus.bvalid && bus.bready) begin b_fire = 1; b_pend = 0; end
    end
    en = 1'b0;

    n_checks++;
    if (bus_done !== 1'b1) begin
      n_fail++; $display("FAIL %s bus_complete: got %0d want 1 (cycle budget expired)", name, bus_done);
    end
    n_checks++;
    if (viol !== 0) begin
      n_fail++; $display("FAIL %s protocol: %0d violations, want 0", name, viol);
    end
    n_checks++;
    if (cap_addr !== t_addr) begin
      n_fail++; $display("FAIL %s bus_addr: got %h want %h", name, cap_addr, t_addr);
    end
    if (t_we) begin
      last_hs = (aw_cyc > w_cyc) ? aw_cyc : w_cyc;
      n_checks++;
      if (cap_wdata !== t_wdata || cap_strb !== t_strb) begin
        n_fail++; $display("FAIL %s bus_wdata: got %h/%b want %h/%b", name, cap_wdata, cap_strb, t_wdata, t_strb);
      end
      n_checks++;
      if (bready_cyc !== last_hs + 1) begin
        n_fail++; $display("FAIL %s bready_rise: got cycle %0d want %0d", name, bready_cyc, last_hs + 1);
      end
    end
    n_checks++;
    if (n_drd !== ((!t_we && !cancelled) ? 1 : 0) || n_dwr !== ((t_we && !cancelled) ? 1 : 0)) begin
      n_fail++; $display("FAIL %s done_pulses: got rd=%0d wr=%0d want rd=%0d wr=%0d", name, n_drd, n_dwr,
                         (!t_we && !cancelled) ? 1 : 0, (t_we && !cancelled) ? 1 : 0);
    end
    if (!cancelled) begin
      exp_lat = t_we ? 3 + ((awd > wd) ? awd : wd) + bd : 3 + ard + rd;
      n_checks++;
      if (done_cyc !== exp_lat) begin
        n_fail++; $display("FAIL %s done_cycle: got %0d want %0d", name, done_cyc, exp_lat);
      end
      if (!t_we) m_rdata = t_rdata;
      m_err = (t_resp != AXI_RESP_OKAY);
    end
    n_checks++;
    if (rdata_o !== m_rdata || err !== m_err) begin
      n_fail++; $display("FAIL %s rdata_err: got %h/%b want %h/%b", name, rdata_o, err, m_rdata, m_err);
    end
  endtask

  task automatic test_reset;
    en = 0; we = 0; addr = '0; wdata = '0; wstrb = '0;
    slave_idle();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({done_rd, done_wr, err} !== 3'b000 || rdata_o !== 32'h0) begin
      n_fail++; $display("FAIL reset_core: got done=%b%b err=%b rdata=%h want 0", done_rd, done_wr, err, rdata_o);
    end
    n_checks++;
    if ({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready} !== 5'b0) begin
      n_fail++; $display("FAIL reset_bus: got %b want 00000", {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready});
    end
    n_checks++;
    if (bus.awaddr !== 32'h0 || bus.wdata !== 32'h0 || bus.awprot !== 3'b000 || bus.arprot !== 3'b000) begin
      n_fail++; $display("FAIL reset_payload: got addr=%h wdata=%h prot=%b/%b want 0", bus.awaddr, bus.wdata, bus.awprot, bus.arprot);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read_zero_wait;
    do_txn(0, 32'h4000_0010, 32'h0, 4'h0, AXI_RESP_OKAY, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0, "read_zero_wait");
  endtask

  task automatic test_write_w_before_aw;
    do_txn(1, 32'h4000_0020, 32'h1234_5678, 4'b0011, AXI_RESP_OKAY, 32'h0, 3, 0, 0, 0, 0, 0, 0, "write_w_first");
  endtask

  task automatic test_slave_error;
    do_txn(0, 32'h4000_0030, 32'h0, 4'h0, AXI_RESP_SLVERR, 32'hCAFE_F00D, 0, 0, 0, 0, 0, 0, 0, "read_slverr");
    do_txn(1, 32'h4000_0034, 32'hA5A5_5A5A, 4'hF, AXI_RESP_OKAY, 32'h0, 0, 0, 0, 0, 0, 0, 0, "write_clears_err");
  endtask

  task automatic test_backpressure;
    do_txn(0, 32'h4000_0040, 32'h0, 4'h0, AXI_RESP_OKAY, 32'h0BAD_CAFE, 0, 0, 0, 5, 7, 0, 1, "read_backpressure");
  endtask

  task automatic test_cancel;
    do_txn(0, 32'h4000_0050, 32'h0, 4'h0, AXI_RESP_OKAY, 32'h1111_2222, 0, 0, 0, 0, 3, 3, 0, "read_cancel");
    do_txn(0, 32'h4000_0054, 32'h0, 4'h0, AXI_RESP_EXOKAY, 32'h3333_4444, 0, 0, 0, 0, 0, 0, 0, "read_after_cancel");
  endtask

  task automatic test_async_reset;
    do_txn(0, 32'h4000_0060, 32'h0, 4'h0, AXI_RESP_DECERR, 32'h5555_6666, 0, 0, 0, 0, 0, 0, 0, "read_decerr");
    en = 1'b1; we = 1'b1; addr = 32'h4000_0064; wdata = 32'h7777_8888; wstrb = 4'hF;
    @(negedge clk);
    bus.awready = 1'b1; bus.wready = 1'b1;
    @(negedge clk);
    bus.awready = 1'b0; bus.wready = 1'b0;
    n_checks++;
    if (bus.bready !== 1'b1) begin
      n_fail++; $display("FAIL async_reset_setup bready: got %b want 1", bus.bready);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready} !== 5'b0) begin
      n_fail++; $display("FAIL async_reset_bus: got %b want 00000", {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready});
    end
    n_checks++;
    if (err !== 1'b0 || rdata_o !== 32'h0) begin
      n_fail++; $display("FAIL async_reset_core: got err=%b rdata=%h want 0/0", err, rdata_o);
    end
    en = 1'b0;
    slave_idle();
    m_rdata = '0; m_err = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_txn(0, 32'h4000_0068, 32'h0, 4'h0, AXI_RESP_OKAY, 32'h9999_AAAA, 0, 0, 0, 1, 1, 0, 0, "read_after_reset");
  endtask

  task automatic test_back_to_back;
    do_txn(1, 32'h4000_0070, 32'h0102_0304, 4'b1000, AXI_RESP_OKAY, 32'h0, 0, 0, 0, 0, 0, 0, 0, "b2b_write");
    do_txn(0, 32'h4000_0074, 32'h0, 4'h0, AXI_RESP_OKAY, 32'hBEEF_0001, 0, 0, 0, 0, 0, 0, 0, "b2b_read");
    do_txn(1, 32'h4000_0078, 32'hFFFF_0000, 4'b1100, AXI_RESP_DECERR, 32'h0, 0, 2, 1, 0, 0, 0, 0, "b2b_aw_first");
  endtask

  task automatic test_random;
    for (int i = 0; i < 24; i++) begin
      bit r_we;
      int r_cancel;
      r_we = 1'($urandom_range(0, 1));
      r_cancel = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0;
      do_txn(r_we, $urandom, $urandom, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), $urandom,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), r_cancel,
             1'($urandom_range(0, 1)), $sformatf("random_%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_w_before_aw();
    test_slave_error();
    test_backpressure();
    test_cancel();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
